// File: rtl/signed_divider.sv
// Iterative signed divider: restoring division on operand magnitudes, one
// quotient bit per clock, followed by a single sign-correction cycle.
module signed_divider #(
  parameter int unsigned N = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);

  localparam int unsigned CW = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  mag_q, mag_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic          sgn_a_q, sgn_a_d;
  logic          sgn_q_q, sgn_q_d;
  logic          zero_q, zero_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N:0]    shifted;

  // Unsigned N-bit magnitude; the most negative value maps onto 2^(N-1).
  function automatic logic [N-1:0] mag_of(input logic [N-1:0] v);
    return v[N-1] ? (~v + N'(1)) : v;
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mag_q   <= '0;
      dvs_q   <= '0;
      sgn_a_q <= 1'b0;
      sgn_q_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mag_q   <= mag_d;
      dvs_q   <= dvs_d;
      sgn_a_q <= sgn_a_d;
      sgn_q_q <= sgn_q_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  // acc_q only ever holds a value below |B|, so N bits suffice; the N+1-bit
  // shifted value carries the extra bit into the compare/subtract.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mag_d   = mag_q;
    dvs_d   = dvs_q;
    sgn_a_d = sgn_a_q;
    sgn_q_d = sgn_q_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    shifted = {acc_q, mag_q[N-1]};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mag_d   = mag_of(A);
          dvs_d   = mag_of(B);
          sgn_a_d = A[N-1];
          sgn_q_d = A[N-1] ^ B[N-1];
          zero_d  = (B == '0);
          cnt_d   = '0;
          busy_d  = 1'b1;
          // Divide by zero parks |A| in the accumulator so FIX restores A.
          if (B == '0) begin
            acc_d   = mag_of(A);
            state_d = S_FIX;
          end else begin
            acc_d   = '0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (shifted >= {1'b0, dvs_q}) begin
          acc_d = N'(shifted - {1'b0, dvs_q});
          mag_d = {mag_q[N-2:0], 1'b1};
        end else begin
          acc_d = shifted[N-1:0];
          mag_d = {mag_q[N-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        quot_d  = zero_q ? '1 : (sgn_q_q ? (~mag_q + N'(1)) : mag_q);
        rem_d   = sgn_a_q ? (~acc_q + N'(1)) : acc_q;
        dbz_d   = zero_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;

endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider: vector table, corner sequences and
// random pairs, with results checked through an expected-result queue.
module tb_signed_divider;

  localparam int unsigned N = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } vec_t;

  vec_t scb[$];

  signed_divider #(.N(N)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [7:0] a, input logic [7:0] b);
    logic signed [7:0] sa, sd, q, r;
    vec_t v;
    sa = a;
    sd = b;
    q  = sa / sd;
    r  = sa % sd;
    v  = '{a, b, q, r, 1'b0};
    return v;
  endfunction

  // Every done pulse consumes one expected result, packed as {q, r, dbz}.
  always @(negedge CLK) begin
    vec_t e;
    if (done === 1'b1) begin
      if (scb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: q=0x%0h r=0x%0h with no division pending", quotient, remainder);
      end else begin
        e = scb.pop_front();
        check($sformatf("result %0h/%0h {q,r,dbz}", e.a, e.b),
              32'({quotient, remainder, div_by_zero}), 32'({e.q, e.r, e.dbz}));
      end
    end
  end

  // Called at a negedge; start is high across exactly one rising edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    A     = a;
    B     = b;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Edges counted inclusively from the start edge to the edge raising done.
  task automatic wait_done(input int exp_edges, input string name);
    int n = 0;
    while (done !== 1'b1 && n < 64) begin
      @(negedge CLK);
      n++;
    end
    check({name, " latency"}, 32'(n + 1), 32'(exp_edges));
  endtask

  initial begin
    vec_t tbl[8];
    vec_t v;
    int   n_done;
    logic [7:0] ra, rb;

    tbl[0] = '{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0};
    tbl[1] = '{8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0};
    tbl[2] = '{8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0};
    tbl[3] = '{8'h9C,  8'hF9,  8'h0E, 8'hFE, 1'b0};
    tbl[4] = '{8'h80,  8'hFF,  8'h80, 8'h00, 1'b0};
    tbl[5] = '{8'h80,  8'h01,  8'h80, 8'h00, 1'b0};
    tbl[6] = '{8'd3,   8'd5,   8'h00, 8'h03, 1'b0};
    tbl[7] = '{8'h7F,  8'h80,  8'h00, 8'h7F, 1'b0};

    // Reset state
    repeat (2) @(negedge CLK);
    check("reset outputs", 32'({busy, done, div_by_zero, quotient, remainder}), 32'(0));
    RST = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 8; i++) begin
      scb.push_back(tbl[i]);
      issue(tbl[i].a, tbl[i].b);
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(1));
      wait_done(10, $sformatf("vec%0d", i));
      @(negedge CLK);
      check($sformatf("vec%0d done one cycle", i), 32'({done, busy}), 32'(0));
    end

    // Divide by zero, flag held until the next valid done clears it
    scb.push_back('{8'd5, 8'd0, 8'hFF, 8'h05, 1'b1});
    issue(8'd5, 8'd0);
    wait_done(2, "dbz");
    @(negedge CLK);
    scb.push_back('{8'd9, 8'd3, 8'h03, 8'h00, 1'b0});
    issue(8'd9, 8'd3);
    check("dbz held while busy", 32'(div_by_zero), 32'(1));
    wait_done(10, "after dbz");
    @(negedge CLK);
    scb.push_back('{8'hFB, 8'd0, 8'hFF, 8'hFB, 1'b1});
    issue(8'hFB, 8'd0);
    wait_done(2, "dbz negative");
    @(negedge CLK);

    // Start while busy is ignored; start in the done cycle is accepted
    scb.push_back('{8'd50, 8'd5, 8'd10, 8'h00, 1'b0});
    issue(8'd50, 8'd5);
    @(negedge CLK);
    @(negedge CLK);
    issue(8'd1, 8'd1);
    A = 8'hAA;
    B = 8'h55;
    wait_done(7, "ignored start");
    scb.push_back('{8'd77, 8'hF9, 8'hF5, 8'h00, 1'b0});
    issue(8'd77, 8'hF9);
    check("back-to-back done dropped", 32'({done, busy}), 32'(1));
    wait_done(10, "back-to-back");
    @(negedge CLK);

    // Asynchronous reset mid-division abandons it without a done
    scb.push_back(tbl[0]);
    issue(8'd100, 8'd7);
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #1 RST = 1'b0;
    #1 check("async reset outputs", 32'({busy, done, div_by_zero, quotient, remainder}), 32'(0));
    scb.delete();
    @(negedge CLK);
    RST = 1'b1;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (done === 1'b1) n_done++;
    end
    check("no done after abort", 32'(n_done), 32'(0));
    scb.push_back('{8'd20, 8'd4, 8'd5, 8'h00, 1'b0});
    issue(8'd20, 8'd4);
    wait_done(10, "after reset");
    @(negedge CLK);

    // Random signed pairs against the language's own / and %
    for (int i = 0; i < 2000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (rb == 8'h00 || (ra == 8'h80 && rb == 8'hFF)) rb = 8'h03;
      v = model(ra, rb);
      scb.push_back(v);
      issue(ra, rb);
      wait_done(10, "random");
      @(negedge CLK);
    end

    repeat (2) @(negedge CLK);
    check("scoreboard drained", 32'(scb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
